mem_lsu: RTL
============

Name: mem_lsu

Overview:
Memory-access stage that sits between ex_mem and mem_wb and drives the mem_wb i_mem_* inputs. Non-memory instructions pass straight through. Loads, stores and LL/SC go through a single-outstanding req/ack data bus, with lane selection and load extension. While a transaction is pending the stage raises a stall request so the pipeline controller holds earlier stages.

Parameters:
N_REG, 32, data/register width (fixed at 32 for lane logic)
N_REG_ADDR, 5, register-file address width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, synchronous, active-low
i_waddr  in  N_REG_ADDR  destination register from ex_mem
i_wdata  in  N_REG  ALU result from ex_mem
i_wen  in  1  register write enable from ex_mem
i_hilo_wen / i_hi / i_lo  in  1/N_REG/N_REG  HI/LO write from ex_mem
i_mem_op  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9 LL, 10 SC, others = NONE
i_mem_addr  in  N_REG  effective address
i_store_data  in  N_REG  rt value for stores
i_llbit  in  1  current LLbit, already forwarded from wb
i_stall  in  6  pipeline stall vector; bit 4 = this stage held
i_flush  in  1  pipeline flush
o_waddr / o_wdata / o_wen  out  N_REG_ADDR/N_REG/1  to mem_wb i_mem_waddr/wdata/wen
o_hilo_wen / o_hi / o_lo  out  1/N_REG/N_REG  to mem_wb
o_llbit_wen / o_llbit_data  out  1/1  to mem_wb
o_adel / o_ades  out  1/1  misaligned load / store address exception
o_stallreq  out  1  stall request to the pipeline controller
o_bus_req / o_bus_we  out  1/1  bus request, write
o_bus_addr  out  N_REG  word address, bits [1:0] = 0
o_bus_sel  out  4  byte enables, big-endian
o_bus_wdata  out  N_REG  lane-replicated store data
i_bus_ack  in  1  one-cycle completion strobe
i_bus_rdata  in  N_REG  read data, valid with ack

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - FSM goes to IDLE; o_bus_req=0, o_bus_we=0, o_bus_addr=0, o_bus_sel=0, o_bus_wdata=0.
  - Captured read data is cleared to 0.
  - Reset mid-transaction abandons it; a late i_bus_ack is ignored.
- Combinational pass-through outputs: o_waddr, o_hilo_wen, o_hi, o_lo. With i_mem_op=NONE, o_wdata, o_wen and o_llbit_* also pass through or are 0 as applicable.
- Alignment:
  - LH/LHU need addr[0]=0; LW/LL/SC need addr[1:0]=0.
  - A misaligned load gives o_adel=1; a misaligned store gives o_ades=1.
  - A misaligned access issues no bus transaction, forces o_wen=0 and o_llbit_wen=0, and asserts no stall.
- SC with i_llbit=0: no bus transaction, no stall; o_wdata=0, o_wen=1, o_llbit_wen=0.
- FSM states IDLE, BUSY, DONE:
  - IDLE, aligned mem op (SC only if i_llbit=1), i_flush=0 → BUSY. o_stallreq=1 combinationally this cycle. Bus outputs are registered next edge: req=1, we=1 for stores/SC, addr={addr[31:2],2'b00}.
  - BUSY: o_stallreq=1; req, we, addr, sel and wdata are held stable until i_bus_ack. On ack: capture i_bus_rdata, req=0, next state DONE. Flush during BUSY has no effect until ack; then go to IDLE, not DONE.
  - DONE: o_stallreq=0; outputs formed from the captured data. Stay in DONE while i_stall[4]=1. Go to IDLE on an edge with i_stall[4]=0 or i_flush=1.
- Minimum cost of a memory op is 2 stall cycles (ack on the first req cycle).
- Byte lanes, big-endian:
  - addr[1:0]=00 → lane [31:24], sel 4'b1000; 01 → [23:16]; 10 → [15:8]; 11 → [7:0], sel 4'b0001.
  - Halfword at addr[1]=0 → [31:16], sel 1100; addr[1]=1 → [15:0], sel 0011.
  - Word → sel 1111.
- Store data is replicated across lanes (SB {4{b}}, SH {2{h}}).
- Load result:
  - LB/LH sign-extend; LBU/LHU zero-extend; LW/LL take the full word.
  - o_wen=i_wen in DONE, and 0 while in IDLE/BUSY for the op.
- LL: o_llbit_wen=1, o_llbit_data=1. SC success: no read; o_wdata=1, o_wen=1, o_llbit_wen=1, o_llbit_data=0.
- Stores: o_wen=0.

Test Plan:
- Reset → IDLE: assert reset with the bus idle → all registered outputs 0, o_stallreq=0.
- Pass-through: i_mem_op=0, i_wdata=32'hDEAD_BEEF, i_wen=1, i_waddr=5 → same-cycle o_wdata=DEADBEEF, o_wen=1, o_stallreq=0.
- LB with wait states: addr=32'h1000_0002, ack after 3 cycles, rdata=32'h1122_8344 → bus_addr=0x10000000, sel=0010, stallreq high 4 cycles, DONE o_wdata=32'hFFFF_FF83. Repeat as LBU → 32'h0000_0083.
- SH: addr=0x...06, store_data=0x0000_ABCD → sel=0011, wdata=0xABCDABCD, we=1, o_wen=0. Misaligned LW at 0x...01 → o_adel=1, no req, no stall.
- LL then SC: LL at 0x2000 → llbit_wen=1, data=1. SC with i_llbit=1 → write with o_wdata=1, llbit_data=0. SC with i_llbit=0 → no req, o_wdata=0.
- Flush/hold/reset:
  - i_flush in BUSY → req held until ack, then IDLE with o_wen=0.
  - i_stall[4]=1 in DONE → outputs stable for 2 cycles.
  - Reset in BUSY → req=0 next edge; a late ack is ignored.

Source files
------------

// File: rtl/mem_lsu.sv
// Memory-access pipeline stage: passes ALU results through, or runs one load/store/LL/SC
// on a single-outstanding req/ack bus. It extracts big-endian lanes and stalls the pipeline while busy.
module mem_lsu #(
  parameter int N_REG      = 32,
  parameter int N_REG_ADDR = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [N_REG_ADDR-1:0] i_waddr,
  input  logic [N_REG-1:0]      i_wdata,
  input  logic                  i_wen,
  input  logic                  i_hilo_wen,
  input  logic [N_REG-1:0]      i_hi,
  input  logic [N_REG-1:0]      i_lo,
  input  logic [3:0]            i_mem_op,
  input  logic [N_REG-1:0]      i_mem_addr,
  input  logic [N_REG-1:0]      i_store_data,
  input  logic                  i_llbit,
  input  logic [5:0]            i_stall,
  input  logic                  i_flush,
  output logic [N_REG_ADDR-1:0] o_waddr,
  output logic [N_REG-1:0]      o_wdata,
  output logic                  o_wen,
  output logic                  o_hilo_wen,
  output logic [N_REG-1:0]      o_hi,
  output logic [N_REG-1:0]      o_lo,
  output logic                  o_llbit_wen,
  output logic                  o_llbit_data,
  output logic                  o_adel,
  output logic                  o_ades,
  output logic                  o_stallreq,
  output logic                  o_bus_req,
  output logic                  o_bus_we,
  output logic [N_REG-1:0]      o_bus_addr,
  output logic [3:0]            o_bus_sel,
  output logic [N_REG-1:0]      o_bus_wdata,
  input  logic                  i_bus_ack,
  input  logic [N_REG-1:0]      i_bus_rdata
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [3:0] OP_LL  = 4'd9;
  localparam logic [3:0] OP_SC  = 4'd10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic             r_flushed;
  logic [N_REG-1:0] r_rdata;
  logic             r_bus_req;
  logic             r_bus_we;
  logic [N_REG-1:0] r_bus_addr;
  logic [3:0]       r_bus_sel;
  logic [N_REG-1:0] r_bus_wdata;

  logic w_lb, w_lbu, w_lh, w_lhu, w_lw, w_sb, w_sh, w_sw, w_ll, w_sc;
  logic w_load, w_store, w_byte, w_half, w_word, w_misalign;
  logic w_sc_fail, w_need_bus, w_issue;
  logic [3:0]       w_sel;
  logic [N_REG-1:0] w_bus_wdata;
  logic [7:0]       w_rbyte;
  logic [15:0]      w_rhalf;
  logic [N_REG-1:0] w_load_data;
  logic             w_unused_stall;

  assign w_lb  = (i_mem_op == OP_LB);
  assign w_lbu = (i_mem_op == OP_LBU);
  assign w_lh  = (i_mem_op == OP_LH);
  assign w_lhu = (i_mem_op == OP_LHU);
  assign w_lw  = (i_mem_op == OP_LW);
  assign w_sb  = (i_mem_op == OP_SB);
  assign w_sh  = (i_mem_op == OP_SH);
  assign w_sw  = (i_mem_op == OP_SW);
  assign w_ll  = (i_mem_op == OP_LL);
  assign w_sc  = (i_mem_op == OP_SC);

  assign w_load  = w_lb | w_lbu | w_lh | w_lhu | w_lw | w_ll;
  assign w_store = w_sb | w_sh | w_sw | w_sc;
  assign w_byte  = w_lb | w_lbu | w_sb;
  assign w_half  = w_lh | w_lhu | w_sh;
  assign w_word  = w_lw | w_sw | w_ll | w_sc;

  assign w_misalign = (w_half & i_mem_addr[0]) | (w_word & (i_mem_addr[1:0] != 2'b00));
  assign w_sc_fail  = w_sc & ~i_llbit;
  assign w_need_bus = (w_load | w_store) & ~w_misalign & ~w_sc_fail;
  assign w_issue    = (r_state == S_IDLE) & w_need_bus & ~i_flush;

  assign o_adel     = w_load & w_misalign;
  assign o_ades     = w_store & w_misalign;
  assign o_stallreq = w_issue | (r_state == S_BUSY);

  assign o_waddr    = i_waddr;
  assign o_hilo_wen = i_hilo_wen;
  assign o_hi       = i_hi;
  assign o_lo       = i_lo;

  assign o_bus_req   = r_bus_req;
  assign o_bus_we    = r_bus_we;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_sel   = r_bus_sel;
  assign o_bus_wdata = r_bus_wdata;

  // Only the "this stage held" bit matters here.
  assign w_unused_stall = ^{i_stall[5], i_stall[3:0]};

  // Big-endian: byte offset 0 is the most significant lane.
  always_comb begin
    w_sel = 4'b1111;
    if (w_byte) begin
      w_sel = 4'b1000 >> i_mem_addr[1:0];
    end else if (w_half) begin
      w_sel = i_mem_addr[1] ? 4'b0011 : 4'b1100;
    end
  end

  always_comb begin
    w_bus_wdata = '0;
    if (w_sb) begin
      w_bus_wdata = {4{i_store_data[7:0]}};
    end else if (w_sh) begin
      w_bus_wdata = {2{i_store_data[15:0]}};
    end else if (w_store) begin
      w_bus_wdata = i_store_data;
    end
  end

  always_comb begin
    w_rbyte = r_rdata[31:24];
    case (i_mem_addr[1:0])
      2'b01:   w_rbyte = r_rdata[23:16];
      2'b10:   w_rbyte = r_rdata[15:8];
      2'b11:   w_rbyte = r_rdata[7:0];
      default: w_rbyte = r_rdata[31:24];
    endcase
    w_rhalf = i_mem_addr[1] ? r_rdata[15:0] : r_rdata[31:16];

    w_load_data = r_rdata;
    if (w_lb) begin
      w_load_data = {{(N_REG-8){w_rbyte[7]}}, w_rbyte};
    end else if (w_lbu) begin
      w_load_data = {{(N_REG-8){1'b0}}, w_rbyte};
    end else if (w_lh) begin
      w_load_data = {{(N_REG-16){w_rhalf[15]}}, w_rhalf};
    end else if (w_lhu) begin
      w_load_data = {{(N_REG-16){1'b0}}, w_rhalf};
    end
  end

  // Write-back side: results only appear once the bus transaction has completed.
  always_comb begin
    o_wdata      = i_wdata;
    o_wen        = i_wen;
    o_llbit_wen  = 1'b0;
    o_llbit_data = 1'b0;
    if (w_misalign) begin
      o_wen = 1'b0;
    end else if (w_sc_fail) begin
      o_wdata = '0;
      o_wen   = 1'b1;
    end else if (w_load | w_store) begin
      o_wen = 1'b0;
      if (r_state == S_DONE) begin
        if (w_load) begin
          o_wdata = w_load_data;
          o_wen   = i_wen;
        end
        if (w_ll) begin
          o_llbit_wen  = 1'b1;
          o_llbit_data = 1'b1;
        end
        if (w_sc) begin
          o_wdata      = {{(N_REG-1){1'b0}}, 1'b1};
          o_wen        = 1'b1;
          o_llbit_wen  = 1'b1;
          o_llbit_data = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_flushed   <= 1'b0;
      r_rdata     <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_sel   <= '0;
      r_bus_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_state     <= S_BUSY;
            r_flushed   <= 1'b0;
            r_bus_req   <= 1'b1;
            r_bus_we    <= w_store;
            r_bus_addr  <= {i_mem_addr[N_REG-1:2], 2'b00};
            r_bus_sel   <= w_sel;
            r_bus_wdata <= w_bus_wdata;
          end
        end
        S_BUSY: begin
          // A flush cannot cancel an issued request; remember it and drop the result.
          if (i_flush) begin
            r_flushed <= 1'b1;
          end
          if (i_bus_ack) begin
            r_rdata   <= i_bus_rdata;
            r_bus_req <= 1'b0;
            r_state   <= (r_flushed | i_flush) ? S_IDLE : S_DONE;
          end
        end
        S_DONE: begin
          if (!i_stall[4] || i_flush) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
